// File: rtl/wash_program_scheduler.sv
// Programme timer/sequencer: latches a wash programme, times wash and spin phases via a prescaled unit counter.
// Optional multi-pass rinse operation enabled by `define WASH_RINSE_EN; programme select port is program_sel (program is reserved).
module wash_program_scheduler #(
  parameter int TICK_DIV = 1000,
  parameter int UNIT_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] program_sel,
  input  logic       wash_active,
  input  logic       spin_active,
  output logic       cycle_time_out,
  output logic       spin_time_out,
  output logic       rinse_req,
  output logic       busy,
  output logic       done
);
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE, WASH_WAIT, WASH_RUN, WASH_EXP, SPIN_WAIT, SPIN_RUN, SPIN_EXP, DONE_S
  } state_t;

  typedef struct packed {
    logic [UNIT_W-1:0] wash;
    logic [UNIT_W-1:0] spin;
`ifdef WASH_RINSE_EN
    logic [1:0]        passes;
`endif
  } prog_cfg_t;

  function automatic prog_cfg_t prog_table(input logic [1:0] p);
    prog_cfg_t c;
    case (p)
      2'd0:    begin c.wash = UNIT_W'(4);  c.spin = UNIT_W'(2); end
      2'd1:    begin c.wash = UNIT_W'(8);  c.spin = UNIT_W'(4); end
      2'd2:    begin c.wash = UNIT_W'(12); c.spin = UNIT_W'(6); end
      default: begin c.wash = UNIT_W'(6);  c.spin = UNIT_W'(1); end
    endcase
`ifdef WASH_RINSE_EN
    case (p)
      2'd1:    c.passes = 2'd2;
      2'd2:    c.passes = 2'd3;
      default: c.passes = 2'd1;
    endcase
`endif
    return c;
  endfunction

  state_t            state_q, state_d;
  logic [1:0]        prog_q, prog_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [UNIT_W-1:0] unit_q, unit_d;
  logic              cto_q, cto_d, sto_q, sto_d, rinse_q, rinse_d;
  logic              busy_q, busy_d, done_q, done_d;
`ifdef WASH_RINSE_EN
  logic [1:0]        pass_q, pass_d;
`endif

  prog_cfg_t         cfg;
  logic              run_active, wrap, hit;
  logic [UNIT_W-1:0] target;

  assign cfg = prog_table(prog_q);

  always_comb begin
    state_d    = state_q;
    prog_d     = prog_q;
    pre_d      = pre_q;
    unit_d     = unit_q;
    cto_d      = cto_q;
    sto_d      = sto_q;
    rinse_d    = rinse_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef WASH_RINSE_EN
    pass_d     = pass_q;
`endif
    run_active = (state_q == SPIN_RUN) ? spin_active : wash_active;
    target     = (state_q == SPIN_RUN) ? cfg.spin : cfg.wash;
    wrap       = (pre_q == PRE_W'(TICK_DIV - 1));
    hit        = 1'b0;

    case (state_q)
      IDLE: if (start) begin
        prog_d  = program_sel;
        busy_d  = 1'b1;
`ifdef WASH_RINSE_EN
        pass_d  = 2'd0;
`endif
        state_d = WASH_WAIT;
      end
      WASH_WAIT: if (wash_active) begin
        pre_d   = '0;
        unit_d  = '0;
        rinse_d = 1'b0;
        state_d = WASH_RUN;
      end
      WASH_RUN, SPIN_RUN: if (run_active) begin
        // Inactive phase input freezes both counters; the unit counter never passes its target.
        if (wrap) begin
          pre_d = '0;
          if (unit_q < target) unit_d = unit_q + 1'b1;
          hit = (unit_d == target);
        end else begin
          pre_d = pre_q + 1'b1;
        end
        if (hit) begin
          if (state_q == WASH_RUN) begin
            cto_d   = 1'b1;
            state_d = WASH_EXP;
          end else begin
            sto_d   = 1'b1;
            state_d = SPIN_EXP;
          end
        end
      end
      WASH_EXP: if (!wash_active) begin
        cto_d   = 1'b0;
        state_d = SPIN_WAIT;
`ifdef WASH_RINSE_EN
        pass_d  = pass_q + 2'd1;
        if ((pass_q + 2'd1) < cfg.passes) begin
          rinse_d = 1'b1;
          state_d = WASH_WAIT;
        end
`endif
      end
      SPIN_WAIT: if (spin_active) begin
        pre_d   = '0;
        unit_d  = '0;
        state_d = SPIN_RUN;
      end
      SPIN_EXP: if (!spin_active) begin
        sto_d   = 1'b0;
        done_d  = 1'b1;
        state_d = DONE_S;
      end
      DONE_S: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      prog_q  <= '0;
      pre_q   <= '0;
      unit_q  <= '0;
      cto_q   <= 1'b0;
      sto_q   <= 1'b0;
      rinse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef WASH_RINSE_EN
      pass_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      prog_q  <= prog_d;
      pre_q   <= pre_d;
      unit_q  <= unit_d;
      cto_q   <= cto_d;
      sto_q   <= sto_d;
      rinse_q <= rinse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef WASH_RINSE_EN
      pass_q  <= pass_d;
`endif
    end
  end

  assign cycle_time_out = cto_q;
  assign spin_time_out  = sto_q;
  assign rinse_req      = rinse_q;
  assign busy           = busy_q;
  assign done           = done_q;
endmodule

// File: tb/tb_wash_program_scheduler.sv
// Bench for wash_program_scheduler: randomized programmes checked against phase lengths from the programme table.
module tb_wash_program_scheduler;
  localparam int TD = 4;

  logic       clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic       wash_active = 1'b0, spin_active = 1'b0;
  logic [1:0] program_sel = 2'd0;
  logic       cycle_time_out, spin_time_out, rinse_req, busy, done;

  int checks = 0, failures = 0;
  int noise = 0;          // 1: spin_active random (wash phase), 2: wash_active random (spin phase)
  bit start_noise = 1'b0;

  int wash_u[4] = '{4, 8, 12, 6};
  int spin_u[4] = '{2, 4, 6, 1};
  int pass_n[4] = '{1, 2, 3, 1};

  wash_program_scheduler #(.TICK_DIV(TD), .UNIT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .program_sel(program_sel),
    .wash_active(wash_active), .spin_active(spin_active),
    .cycle_time_out(cycle_time_out), .spin_time_out(spin_time_out),
    .rinse_req(rinse_req), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    if (noise == 1) spin_active = 1'($urandom_range(0, 1));
    else if (noise == 2) wash_active = 1'($urandom_range(0, 1));
    if (start_noise) begin
      start       = ($urandom_range(0, 5) == 0);
      program_sel = 2'($urandom_range(0, 3));
    end
    @(posedge clk); #1;
  endtask

  function automatic logic out_of(input bit sp);
    return sp ? spin_time_out : cycle_time_out;
  endfunction

  task automatic set_act(input bit sp, input logic v);
    if (sp) spin_active = v; else wash_active = v;
  endtask

  // One wash or spin phase, from WAIT to just before the active input is dropped.
  task automatic phase(input bit sp, input int units, input int pa, input int pl);
    int cnt, lim;
    bit seen;
    repeat ($urandom_range(0, 3)) begin
      step();
      chk(sp ? "sto_in_wait" : "cto_in_wait", out_of(sp), 0);
    end
    set_act(sp, 1'b1);
    step();
    chk("rinse_clear", rinse_req, 0);
    cnt = 0; seen = 1'b0; lim = units * TD + pl + 16;
    while (!seen && cnt < lim) begin
      if (cnt == pa) begin
        set_act(sp, 1'b0);
        repeat (pl) begin step(); cnt++; end
        set_act(sp, 1'b1);
      end
      step(); cnt++;
      seen = out_of(sp);
    end
    chk(sp ? "spin_len" : "wash_len", cnt, units * TD + pl);
    repeat ($urandom_range(1, 4)) begin
      step();
      chk(sp ? "sto_hold" : "cto_hold", out_of(sp), 1);
    end
    set_act(sp, 1'b0);
  endtask

  task automatic run_prog(input int p, input int pa, input int pl);
    int np;
`ifdef WASH_RINSE_EN
    np = pass_n[p];
`else
    np = 1;
`endif
    program_sel = 2'(p); start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_rise", busy, 1);
    chk("cto_at_start", cycle_time_out, 0);
    noise = 1; start_noise = 1'b1;
    for (int i = 0; i < np; i++) begin
      phase(1'b0, wash_u[p], (i == 0) ? pa : -1, (i == 0) ? pl : 0);
      step();
      chk("cto_fall", cycle_time_out, 0);
      chk("rinse_req", rinse_req, (i < np - 1) ? 1 : 0);
      chk("busy_mid", busy, 1);
    end
    spin_active = 1'b0; noise = 2;
    phase(1'b1, spin_u[p], -1, 0);
    start_noise = 1'b0; start = 1'b0;
    step();
    chk("sto_fall", spin_time_out, 0);
    chk("done_pulse", done, 1);
    chk("busy_in_done", busy, 1);
    noise = 0; wash_active = 1'b0;
    step();
    chk("done_end", done, 0);
    chk("busy_end", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, pa, pl;
    reset = 1'b0; start = 1'b1;
    repeat (3) begin
      step();
      chk("rst_cto", cycle_time_out, 0);
      chk("rst_sto", spin_time_out, 0);
      chk("rst_rinse", rinse_req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
    end
    start = 1'b0; reset = 1'b1;
    step();
    chk("idle_busy", busy, 0);

    run_prog(0, -1, 0);
    run_prog(1, 3 * TD, 10);
    run_prog(2, -1, 0);
    run_prog(3, -1, 0);
    repeat (4) begin
      p  = $urandom_range(0, 3);
      pa = ($urandom_range(0, 1) == 1) ? $urandom_range(0, wash_u[p] * TD - 1) : -1;
      pl = (pa >= 0) ? $urandom_range(1, 8) : 0;
      run_prog(p, pa, pl);
    end

    // Abort with reset in SPIN_RUN.
    program_sel = 2'd0; start = 1'b1;
    step();
    start = 1'b0; noise = 1;
    phase(1'b0, wash_u[0], -1, 0);
    step();
    noise = 0; spin_active = 1'b1;
    repeat (3) step();
    chk("abort_busy_pre", busy, 1);
    reset = 1'b0;
    step();
    reset = 1'b1; spin_active = 1'b0; wash_active = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_sto", spin_time_out, 0);
    chk("abort_cto", cycle_time_out, 0);
    chk("abort_done", done, 0);
    repeat (3) begin
      step();
      chk("abort_no_done", done, 0);
      chk("abort_idle_busy", busy, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wash_program_scheduler.md
# wash_program_scheduler

Programme timer/sequencer for the automatic washing machine controller. It latches a wash programme at start, times the wash (motor) and dry-spin phases with a prescaled unit counter, and drives the controller's `cycle_time_out` and `spin_time_out` inputs. It sits between the front-panel programme selector and the washing-machine FSM, replacing the free-running external timeout sources.

## Interface
- `TICK_DIV`, default 1000: clk cycles per time unit (≥2).
- `UNIT_W`, default 4: width of the unit counter; must hold 15.
- `clk`  input  1  system clock, all logic on rising edge.
- `reset`  input  1  synchronous, active-low; asserted when 0 at a rising edge.
- `start`  input  1  programme start; sampled only in IDLE.
- `program`  input  2  0 quick, 1 normal, 2 heavy, 3 delicate; latched on accepted start.
- `wash_active`  input  1  high while the washer FSM is in its wash-cycle state.
- `spin_active`  input  1  high while the washer FSM is in its dry-spin state.
- `cycle_time_out`  output  1  registered; wash phase expired.
- `spin_time_out`  output  1  registered; spin phase expired.
- `rinse_req`  output  1  registered; request refill for another wash pass (see Configuration).
- `busy`  output  1  registered; high from accepted start until DONE completes.
- `done`  output  1  registered; one-cycle pulse at programme end.

## Operation
- Programme table (wash units / spin units / passes): quick 4/2/1, normal 8/4/2, heavy 12/6/3, delicate 6/1/1.
- States: IDLE, WASH_WAIT, WASH_RUN, WASH_EXP, SPIN_WAIT, SPIN_RUN, SPIN_EXP, DONE.
- IDLE: `start`=1 → latch `program`, `busy`=1, pass count = 0, go WASH_WAIT.
- WASH_WAIT: `wash_active`=1 → WASH_RUN; clear prescaler and unit counter.
- WASH_RUN: prescaler counts 0..TICK_DIV-1 while `wash_active`=1. Each wrap increments the unit counter. When the unit counter reaches the wash target → WASH_EXP, `cycle_time_out`=1.
- Pause: `wash_active`=0 in WASH_RUN freezes the prescaler and unit counter. Counting resumes from the frozen values when it returns to 1.
- WASH_EXP: `cycle_time_out` held 1 while `wash_active`=1. On `wash_active`=0, clear `cycle_time_out` and increment the pass count.
  - If passes remain (macro only): assert `rinse_req`, go WASH_WAIT.
  - Otherwise: go SPIN_WAIT.
- SPIN_WAIT / SPIN_RUN / SPIN_EXP: same rules as the wash states, using `spin_active`, the spin target and `spin_time_out`. When `spin_active` falls in SPIN_EXP → DONE.
- DONE: `done`=1 for one cycle, `busy`=0, return to IDLE.
- In wash states `spin_active` is ignored; in spin states `wash_active` is ignored.
- `start` outside IDLE is ignored. `program` changes after latch have no effect.
- Unit counter saturates at the target; no wrap.

## Timing
- Reset (reset=0 at an edge): state IDLE; all outputs 0; counters 0; latched programme 0. Reset mid-programme aborts immediately with no `done` pulse.
- Start to WASH_WAIT: 1 cycle; `busy` rises on the edge that samples `start`.
- With `wash_active` held high from the WASH_RUN entry edge, `cycle_time_out` rises exactly N×TICK_DIV cycles later (N = wash units). Spin phase is identical with the spin target.
- Timeout falls on the edge after the corresponding `*_active` is sampled 0.
- `rinse_req` rises on that same edge and falls on the edge after `wash_active` is sampled 1 in WASH_WAIT.
- `done` pulses on the edge after `spin_active` is sampled 0 in SPIN_EXP. IDLE accepts a new `start` on the next cycle.

## Configuration
- `WASH_RINSE_EN` defined: multi-pass operation per the programme table. `rinse_req` is driven and passes are counted.
- `WASH_RINSE_EN` undefined:
  - Every programme runs exactly one wash pass, then spin.
  - `rinse_req` is tied 0.
  - No pass counter is synthesised.

## Test plan
All scenarios run with TICK_DIV=4.
- Reset: hold reset=0 for 3 cycles with start=1 → all outputs 0; `busy` stays 0.
- Quick programme: start with program=0, `wash_active` high → `cycle_time_out` rises 16 cycles after WASH_RUN entry. Drop `wash_active`, raise `spin_active` → `spin_time_out` rises after 8 cycles. Drop `spin_active` → one-cycle `done`, `busy`=0.
- Pause: normal programme; drop `wash_active` for 10 cycles at unit 3 → `cycle_time_out` arrives 32+10 cycles after WASH_RUN entry.
- Rinse (macro defined): heavy programme → `rinse_req` asserted twice, three `cycle_time_out` assertions of 48 cycles each, then spin of 24 cycles. Macro undefined → one wash pass, `rinse_req` never 1.
- Boundaries:
  - `start` pulsed mid-wash → ignored; the latched programme is unchanged.
  - reset=0 in SPIN_RUN → IDLE, outputs 0, no `done` pulse.
